// File: rtl/synth_pkg.sv
// Shared types and constants for the synth parameter controller: selector
// indices, reset values, octave range and the auto-repeat state encoding.
package synth_pkg;

  localparam int PARAM_W  = 4;
  localparam int NUM_ADSR = 5;

  typedef logic [PARAM_W-1:0]                param_t;
  typedef logic [NUM_ADSR-1:0][PARAM_W-1:0]  adsr_t;

  localparam logic [2:0] SEL_VOLUME  = 3'd0;
  localparam logic [2:0] SEL_ATTACK  = 3'd1;
  localparam logic [2:0] SEL_DECAY   = 3'd2;
  localparam logic [2:0] SEL_SUSTAIN = 3'd3;
  localparam logic [2:0] SEL_RELEASE = 3'd4;

  localparam logic [2:0] OCT_MIN   = 3'd0;
  localparam logic [2:0] OCT_MAX   = 3'd7;
  localparam logic [2:0] OCT_RESET = 3'd4;

  localparam param_t VOL_RESET = 4'd8;
  localparam param_t ATT_RESET = 4'd2;
  localparam param_t DEC_RESET = 4'd4;
  localparam param_t SUS_RESET = 4'd10;
  localparam param_t REL_RESET = 4'd4;

  // Element i of the packed vector is the value addressed by selector i.
  localparam adsr_t ADSR_RESET = {REL_RESET, SUS_RESET, DEC_RESET, ATT_RESET, VOL_RESET};

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  function automatic param_t sat_step(input param_t val, input logic up, input logic dn,
                                      input param_t max_v);
    if (up && !dn && val < max_v) return val + param_t'(1);
    if (dn && !up && val > '0)    return val - param_t'(1);
    return val;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Edge detect plus hold-to-repeat FSM for a +/- key pair; emits one-cycle
// step_up_o / step_down_o pulses.
module key_repeat
  import synth_pkg::*;
#(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic up_i,
  input  logic dn_i,
  output logic step_up_o,
  output logic step_down_o
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_CNT = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_CNT  = CW'(REPEAT_RATE);

  rpt_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    hist_q;
  logic          up_edge, dn_edge, both, single;

  assign up_edge = up_i & ~hist_q[1];
  assign dn_edge = dn_i & ~hist_q[0];
  assign both    = up_i & dn_i;
  assign single  = up_i ^ dn_i;

  // History loads the live key levels during reset so a key held across
  // reset is not mistaken for a fresh press.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    hist_q <= {up_i, dn_i};
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a comb output unassigned (latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RPT_IDLE: begin
        cnt_d = '0;
        if (!both && (up_edge || dn_edge)) begin
          state_d = RPT_DELAY;
          cnt_d   = CW'(1);
        end
      end
      RPT_DELAY: begin
        if (!single) begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DELAY_CNT) begin
          state_d = RPT_REPEAT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RPT_REPEAT: begin
        if (!single) begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RATE_CNT) begin
          cnt_d = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RPT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic fire;
  always_comb begin
    fire = 1'b0;
    unique case (state_q)
      RPT_IDLE:   fire = !both && (up_edge || dn_edge);
      RPT_DELAY:  fire = single && (cnt_q == DELAY_CNT);
      RPT_REPEAT: fire = single && (cnt_q == RATE_CNT);
      default:    fire = 1'b0;
    endcase
    step_up_o   = fire & up_i;
    step_down_o = fire & dn_i;
  end

endmodule

// File: rtl/synth_param_ctrl.sv
// Synth front-panel controller: registers PS/2 decoder outputs and maintains
// note, octave and ADSR/volume state with hold-to-repeat on the ADSR keys.
module synth_param_ctrl
  import synth_pkg::*;
#(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int PARAM_MAX    = 15
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         note_in,
  input  logic [3:0]   note,
  input  logic         octave_minus_minus,
  input  logic         octave_plus_plus,
  input  logic         ADSR_minus_minus,
  input  logic         ADSR_plus_plus,
  input  logic [2:0]   ADSR_selector,
  input  logic         sine,
  input  logic [1:0]   overdrive,
  output logic [3:0]   note_out,
  output logic         gate,
  output logic         note_on_pulse,
  output logic [2:0]   octave,
  output logic [3:0]   volume,
  output logic [3:0]   attack,
  output logic [3:0]   decay,
  output logic [3:0]   sustain,
  output logic [3:0]   release_o,  // "release" is a reserved word
  output logic         sine_out,
  output logic [1:0]   overdrive_out,
  output logic         param_changed
);

  localparam param_t PMAX = param_t'(PARAM_MAX);

  logic       note_in_q, oct_dn_q, oct_up_q, adsr_dn_q, adsr_up_q, sine_q;
  logic [3:0] note_q;
  logic [2:0] sel_q;
  logic [1:0] od_q;

  // NOTE: the input stage has no reset; it only resamples the pins, and the
  // edge history needs the true key level while reset is held.
  always_ff @(posedge CLOCK_50) begin
    note_in_q <= note_in;
    note_q    <= note;
    oct_dn_q  <= octave_minus_minus;
    oct_up_q  <= octave_plus_plus;
    adsr_dn_q <= ADSR_minus_minus;
    adsr_up_q <= ADSR_plus_plus;
    sel_q     <= ADSR_selector;
    sine_q    <= sine;
    od_q      <= overdrive;
  end

  logic step_up, step_dn;

  key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_adsr_repeat (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .up_i       (adsr_up_q),
    .dn_i       (adsr_dn_q),
    .step_up_o  (step_up),
    .step_down_o(step_dn)
  );

  logic [1:0] oct_hist_q;
  logic [2:0] octave_q, octave_d;
  adsr_t      adsr_q, adsr_d;
  logic       param_changed_q, param_changed_d;
  logic       gate_q, note_on_pulse_q, note_on_pulse_d, sine_out_q;
  logic [3:0] note_out_q, note_out_d;
  logic [1:0] od_out_q;
  logic       oct_up_edge, oct_dn_edge;

  assign oct_up_edge = oct_up_q & ~oct_hist_q[1];
  assign oct_dn_edge = oct_dn_q & ~oct_hist_q[0];

  always_comb begin
    octave_d = octave_q;
    if (oct_up_edge && !oct_dn_edge && octave_q != OCT_MAX)
      octave_d = octave_q + 3'd1;
    else if (oct_dn_edge && !oct_up_edge && octave_q != OCT_MIN)
      octave_d = octave_q - 3'd1;

    adsr_d = adsr_q;
    for (int i = 0; i < NUM_ADSR; i++) begin
      if (sel_q == 3'(i)) adsr_d[i] = sat_step(adsr_q[i], step_up, step_dn, PMAX);
    end

    // Saturated steps leave the value equal, so they raise no pulse.
    param_changed_d = (octave_d != octave_q) || (adsr_d != adsr_q);

    note_out_d      = note_in_q ? note_q : note_out_q;
    note_on_pulse_d = note_in_q & (~gate_q | (note_q != note_out_q));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      octave_q        <= OCT_RESET;
      adsr_q          <= ADSR_RESET;
      param_changed_q <= 1'b0;
      note_out_q      <= '0;
      gate_q          <= 1'b0;
      note_on_pulse_q <= 1'b0;
      sine_out_q      <= 1'b0;
      od_out_q        <= '0;
    end else begin
      octave_q        <= octave_d;
      adsr_q          <= adsr_d;
      param_changed_q <= param_changed_d;
      note_out_q      <= note_out_d;
      gate_q          <= note_in_q;
      note_on_pulse_q <= note_on_pulse_d;
      sine_out_q      <= sine_q;
      od_out_q        <= od_q;
    end
    oct_hist_q <= {oct_up_q, oct_dn_q};
  end

  assign octave        = octave_q;
  assign volume        = adsr_q[SEL_VOLUME];
  assign attack        = adsr_q[SEL_ATTACK];
  assign decay         = adsr_q[SEL_DECAY];
  assign sustain       = adsr_q[SEL_SUSTAIN];
  assign release_o     = adsr_q[SEL_RELEASE];
  assign param_changed = param_changed_q;
  assign note_out      = note_out_q;
  assign gate          = gate_q;
  assign note_on_pulse = note_on_pulse_q;
  assign sine_out      = sine_out_q;
  assign overdrive_out = od_out_q;

endmodule
